// File: rtl/umi_queue_pkg.sv
// Shared definitions for the switchboard-queue <-> UMI bridge: flit field layout,
// UMI command/address bit positions, receive FSM states and error-flag indices.
package umi_queue_pkg;

  localparam int UMI_EOM_BIT = 22;
  localparam int CHIPID_MSB  = 55;
  localparam int CHIPID_LSB  = 40;
  localparam int CHIPID_W    = CHIPID_MSB - CHIPID_LSB + 1;

  localparam int ERR_LAST   = 0;
  localparam int ERR_DEST   = 1;
  localparam int ERR_SWITCH = 2;
  localparam int ERR_W      = 3;

  // Flit is {data, srcaddr, dstaddr, cmd} with cmd in the LSBs.
  localparam int CMD_LSB = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_MSG = 1'b1
  } rx_state_t;

  function automatic int dst_lsb(input int cw);
    return CMD_LSB + cw;
  endfunction

  function automatic int src_lsb(input int aw, input int cw);
    return CMD_LSB + cw + aw;
  endfunction

  function automatic int data_lsb(input int aw, input int cw);
    return CMD_LSB + cw + 2 * aw;
  endfunction

  function automatic int flit_w(input int dw, input int aw, input int cw);
    return dw + 2 * aw + cw;
  endfunction

endpackage

// File: rtl/umi_queue_fifo2.sv
// Two-entry elastic buffer: head register feeds the output directly, the tail
// register absorbs one extra word so the input side never sees the output ready.
module umi_queue_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head_p1;
  logic [W-1:0] tail_p1;
  logic [1:0]   occ_p1;
  logic         push_ok;
  logic         pop_ok;

  assign full    = occ_p1[1];
  assign empty   = (occ_p1 == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = head_p1;

  // Storage stage: simultaneous push/pop only happens at occupancy 1 (full blocks push)
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      occ_p1  <= 2'd0;
      head_p1 <= '0;
      tail_p1 <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (empty) head_p1 <= din;
          else       tail_p1 <= din;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          head_p1 <= tail_p1;
          occ_p1  <= occ_p1 - 2'd1;
        end
        2'b11: begin
          head_p1 <= din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/queue_to_umi_rx.sv
// Unpacks switchboard flits onto a UMI valid/ready port, checking framing and routing.
// Build option QUEUE_TO_UMI_DROP_ERR_EN: flits failing the EOM or destination check are discarded.
module queue_to_umi_rx
  import umi_queue_pkg::*;
#(
  parameter int DW   = 256,
  parameter int AW   = 64,
  parameter int CW   = 32,
  parameter int CNTW = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [DW+2*AW+CW-1:0] sb_data,
  input  logic [31:0]           sb_dest,
  input  logic                  sb_last,
  input  logic                  sb_valid,
  output logic                  sb_ready,
  output logic [DW-1:0]         umi_data,
  output logic [AW-1:0]         umi_srcaddr,
  output logic [AW-1:0]         umi_dstaddr,
  output logic [CW-1:0]         umi_cmd,
  output logic                  umi_valid,
  input  logic                  umi_ready,
  input  logic                  err_clear,
  output logic [ERR_W-1:0]      err_flags,
  output logic                  in_msg,
  output logic [CNTW-1:0]       flit_count,
  output logic [CNTW-1:0]       msg_count
);

  localparam int FW       = flit_w(DW, AW, CW);
  localparam int DST_LSB  = dst_lsb(CW);
  localparam int SRC_LSB  = src_lsb(AW, CW);
  localparam int DATA_LSB = data_lsb(AW, CW);
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FW-1:0]        head;
  logic                 in_eom;
  logic [CHIPID_W-1:0]  in_chip;
  logic                 e_last;
  logic                 e_dest;
  logic                 e_switch;
  logic [ERR_W-1:0]     err_new;
  logic [ERR_W-1:0]     err_p1;
  logic [CHIPID_W-1:0]  chip_p1;
  logic [CNTW-1:0]      flit_cnt_p1;
  logic [CNTW-1:0]      msg_cnt_p1;
  rx_state_t            state_p1;
  rx_state_t            state_nx;

  // Ready depends only on registered occupancy; held low while reset is asserted.
  assign sb_ready = nreset & ~fifo_full;
  assign accept   = sb_valid & sb_ready;
  assign in_eom   = sb_data[CMD_LSB + UMI_EOM_BIT];
  assign in_chip  = sb_data[DST_LSB + CHIPID_LSB +: CHIPID_W];

  assign e_last   = (sb_last != in_eom);
  assign e_dest   = (sb_dest != {16'h0000, in_chip});
  assign e_switch = (state_p1 == IN_MSG) && (in_chip != chip_p1);

`ifdef QUEUE_TO_UMI_DROP_ERR_EN
  assign drop = e_last | e_dest;
`else
  assign drop = 1'b0;
`endif

  assign push = accept & ~drop;
  assign pop  = umi_valid & umi_ready;

  umi_queue_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .din    (sb_data),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign umi_valid   = ~fifo_empty;
  assign umi_cmd     = head[CMD_LSB +: CW];
  assign umi_dstaddr = head[DST_LSB +: AW];
  assign umi_srcaddr = head[SRC_LSB +: AW];
  assign umi_data    = head[DATA_LSB +: DW];

  always_comb begin
    err_new             = '0;
    err_new[ERR_LAST]   = accept & e_last;
    err_new[ERR_DEST]   = accept & e_dest;
    err_new[ERR_SWITCH] = accept & e_switch;
  end

  // Message-tracking FSM, advanced only by accepted flits
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_p1 <= IDLE;
    else         state_p1 <= state_nx;
  end

  always_comb begin
    state_nx = state_p1;
    if (accept) begin
      case (state_p1)
        IDLE:   if (!sb_last) state_nx = IN_MSG;
        IN_MSG: if (sb_last)  state_nx = IDLE;
      endcase
    end
  end

  // Status stage: chip id, sticky errors (new errors beat a clear) and counters
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      chip_p1     <= '0;
      err_p1      <= '0;
      flit_cnt_p1 <= '0;
      msg_cnt_p1  <= '0;
    end else begin
      if (accept && (state_p1 == IDLE)) chip_p1 <= in_chip;
      err_p1 <= (err_p1 & ~{ERR_W{err_clear}}) | err_new;
      if (accept)           flit_cnt_p1 <= sat_inc(flit_cnt_p1);
      if (push && sb_last)  msg_cnt_p1  <= sat_inc(msg_cnt_p1);
    end
  end

  assign err_flags  = err_p1;
  assign in_msg     = (state_p1 == IN_MSG);
  assign flit_count = flit_cnt_p1;
  assign msg_count  = msg_cnt_p1;

endmodule

// File: tb/tb_queue_to_umi_rx.sv
// Directed bench for queue_to_umi_rx with a queue-based reference model checked every cycle.
module tb_queue_to_umi_rx;

  localparam int DW = 64, AW = 64, CW = 32, CNTW = 4;
  localparam int FW = DW + 2 * AW + CW;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [CW-1:0] cmd;
  } flit_t;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [FW-1:0]   sb_data = '0;
  logic [31:0]     sb_dest = '0;
  logic            sb_last = 1'b0;
  logic            sb_valid = 1'b0;
  logic            sb_ready;
  logic [DW-1:0]   umi_data;
  logic [AW-1:0]   umi_srcaddr;
  logic [AW-1:0]   umi_dstaddr;
  logic [CW-1:0]   umi_cmd;
  logic            umi_valid;
  logic            umi_ready = 1'b1;
  logic            err_clear = 1'b0;
  logic [2:0]      err_flags;
  logic            in_msg;
  logic [CNTW-1:0] flit_count;
  logic [CNTW-1:0] msg_count;

  int n_chk = 0;
  int n_pass = 0;

  queue_to_umi_rx #(.DW(DW), .AW(AW), .CW(CW), .CNTW(CNTW)) dut (
    .clk(clk), .nreset(nreset), .sb_data(sb_data), .sb_dest(sb_dest),
    .sb_last(sb_last), .sb_valid(sb_valid), .sb_ready(sb_ready),
    .umi_data(umi_data), .umi_srcaddr(umi_srcaddr), .umi_dstaddr(umi_dstaddr),
    .umi_cmd(umi_cmd), .umi_valid(umi_valid), .umi_ready(umi_ready),
    .err_clear(err_clear), .err_flags(err_flags), .in_msg(in_msg),
    .flit_count(flit_count), .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: list of buffered flits plus message/error/counter state
  flit_t     mq[$];
  flit_t     m_f;
  logic [2:0] m_err = 3'b000;
  logic      m_in_msg = 1'b0;
  logic [15:0] m_chip = 16'h0;
  int        m_fc = 0;
  int        m_mc = 0;
  bit        m_acc, m_pop, m_e0, m_e1, m_e2, m_drop;

  task model_step();
    if (!nreset) begin
      mq.delete();
      m_err = 3'b000; m_in_msg = 1'b0; m_chip = 16'h0; m_fc = 0; m_mc = 0;
    end else begin
      m_f   = sb_data;
      m_acc = sb_valid && (mq.size() < 2);
      m_pop = (mq.size() > 0) && umi_ready;
      if (m_pop) void'(mq.pop_front());
      if (err_clear) m_err = 3'b000;
      if (m_acc) begin
        m_e0 = (sb_last != m_f.cmd[22]);
        m_e1 = (sb_dest != {16'h0000, m_f.dst[55:40]});
        m_e2 = m_in_msg && (m_f.dst[55:40] != m_chip);
        m_err = m_err | {m_e2, m_e1, m_e0};
`ifdef QUEUE_TO_UMI_DROP_ERR_EN
        m_drop = m_e0 || m_e1;
`else
        m_drop = 1'b0;
`endif
        if (!m_drop) mq.push_back(m_f);
        if (!m_drop && sb_last) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
        m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        if (!m_in_msg) m_chip = m_f.dst[55:40];
        m_in_msg = !sb_last;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge nreset);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("sb_ready", sb_ready, (nreset && mq.size() < 2));
    chk("umi_valid", umi_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      chk("umi_data", umi_data, mq[0].data);
      chk("umi_srcaddr", umi_srcaddr, mq[0].src);
      chk("umi_dstaddr", umi_dstaddr, mq[0].dst);
      chk("umi_cmd", umi_cmd, mq[0].cmd);
    end
    chk("err_flags", err_flags, m_err);
    chk("in_msg", in_msg, m_in_msg);
    chk("flit_count", flit_count, m_fc[CNTW-1:0]);
    chk("msg_count", msg_count, m_mc[CNTW-1:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mkf(input logic [31:0] cmd, input logic [63:0] dst,
                                input logic [63:0] src, input logic [63:0] data);
    flit_t f;
    f.cmd = cmd; f.dst = dst; f.src = src; f.data = data;
    return f;
  endfunction

  task automatic send(input flit_t f, input logic [31:0] dest, input logic last);
    int t = 0;
    sb_data = f; sb_dest = dest; sb_last = last; sb_valid = 1'b1;
    while (!sb_ready && t < 50) begin
      step();
      t++;
    end
    chk("send_ready", sb_ready, 1'b1);
    step();
    sb_valid = 1'b0;
  endtask

  task automatic do_reset();
    sb_valid = 1'b0; err_clear = 1'b0;
    nreset = 1'b0;
    step();
    chk("rst_umi_valid", umi_valid, 1'b0);
    chk("rst_sb_ready", sb_ready, 1'b0);
    chk("rst_umi_data", umi_data, 64'h0);
    chk("rst_umi_cmd", umi_cmd, 32'h0);
    chk("rst_flit_count", flit_count, 4'h0);
    step();
    nreset = 1'b1;
    #1;
    chk("rel_sb_ready", sb_ready, 1'b1);
  endtask

  localparam logic [63:0] DST12 = 64'h0000_1234_0000_0000;
  localparam logic [63:0] DST13 = 64'h0000_1334_0000_0000;
  localparam logic [31:0] CEOM  = 32'h0040_0003;
  localparam logic [31:0] CMID  = 32'h0000_0003;

  initial begin
    do_reset();

    // Single flit after reset
    umi_ready = 1'b1;
    send(mkf(CEOM, DST12, 64'hAAAA_0000_0000_0001, 64'hDEAD_BEEF_0123_4567), 32'h12, 1'b1);
    chk("t1_valid", umi_valid, 1'b1);
    chk("t1_cmd", umi_cmd, 32'h0040_0003);
    chk("t1_dst", umi_dstaddr, 64'h0000_1234_0000_0000);
    chk("t1_data", umi_data, 64'hDEAD_BEEF_0123_4567);
    chk("t1_msg_count", msg_count, 4'h1);
    chk("t1_err", err_flags, 3'b000);
    step();
    chk("t1_drained", umi_valid, 1'b0);

    // Backpressure: two accepted, third stalls until the sink drains
    do_reset();
    umi_ready = 1'b0;
    send(mkf(CEOM, DST12, 64'h1, 64'hA0), 32'h12, 1'b1);
    send(mkf(CEOM, DST12, 64'h2, 64'hB0), 32'h12, 1'b1);
    sb_data = mkf(CEOM, DST12, 64'h3, 64'hC0); sb_dest = 32'h12; sb_last = 1'b1; sb_valid = 1'b1;
    chk("t2_full_ready", sb_ready, 1'b0);
    step(); step();
    chk("t2_still_full", sb_ready, 1'b0);
    chk("t2_head", umi_data, 64'hA0);
    umi_ready = 1'b1;
    send(mkf(CEOM, DST12, 64'h3, 64'hC0), 32'h12, 1'b1);
    chk("t2_head_c", umi_data, 64'hC0);
    chk("t2_flit_count", flit_count, 4'h3);
    step();
    chk("t2_empty", umi_valid, 1'b0);

    // Framing error, clear, then clear colliding with a new error
    do_reset();
    send(mkf(CMID, DST12, 64'h5, 64'h55), 32'h12, 1'b1);
    chk("t3_err", err_flags, 3'b001);
`ifdef QUEUE_TO_UMI_DROP_ERR_EN
    chk("t3_dropped", umi_valid, 1'b0);
`else
    chk("t3_forwarded", umi_valid, 1'b1);
`endif
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t3_cleared", err_flags, 3'b000);
    err_clear = 1'b1;
    send(mkf(CMID, DST12, 64'h6, 64'h66), 32'h12, 1'b1);
    err_clear = 1'b0;
    chk("t3_set_wins", err_flags, 3'b001);

    // Chip id switches mid-message
    do_reset();
    send(mkf(CMID, DST12, 64'h7, 64'h71), 32'h12, 1'b0);
    chk("t4_in_msg1", in_msg, 1'b1);
    send(mkf(CMID, DST13, 64'h7, 64'h72), 32'h13, 1'b0);
    chk("t4_in_msg2", in_msg, 1'b1);
    chk("t4_err2", err_flags, 3'b100);
    send(mkf(CEOM, DST12, 64'h7, 64'h73), 32'h12, 1'b1);
    chk("t4_in_msg3", in_msg, 1'b0);
    chk("t4_err3", err_flags, 3'b100);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++)
      send(mkf(CEOM, DST12, 64'(i), 64'(i * 3)), 32'h12, 1'b1);
    chk("t5_flit_sat", flit_count, 4'hF);
    chk("t5_msg_sat", msg_count, 4'hF);

    // Asynchronous reset with data buffered mid-message
    do_reset();
    umi_ready = 1'b0;
    send(mkf(CMID, DST12, 64'h8, 64'h81), 32'h12, 1'b0);
    send(mkf(CMID, DST12, 64'h8, 64'h82), 32'h12, 1'b0);
    chk("t6_in_msg", in_msg, 1'b1);
    chk("t6_full", sb_ready, 1'b0);
    #1 nreset = 1'b0;
    #1;
    chk("t6_valid0", umi_valid, 1'b0);
    chk("t6_in_msg0", in_msg, 1'b0);
    chk("t6_fc0", flit_count, 4'h0);
    chk("t6_err0", err_flags, 3'b000);
    chk("t6_ready0", sb_ready, 1'b0);
    step();
    nreset = 1'b1;
    #1;
    chk("t6_ready1", sb_ready, 1'b1);
    umi_ready = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
